// File: rtl/wb_commit_pkg.sv
// wb_commit_pkg: shared widths and constants for the writeback commit block.
// Mirrors the OpenMIPS define.v values so the commit logic reads in the
// same terms as the rest of the pipeline. Also holds the GPR read-port
// priority function shared by both read ports.
package wb_commit_pkg;

    localparam int unsigned REG_BUS      = 32;
    localparam int unsigned REG_ADDR_BUS = 5;
    localparam int unsigned REG_NUM      = 32;
    localparam int unsigned REG_NUM_LOG2 = 5;

    localparam logic [REG_BUS-1:0]      ZERO_WORD    = 32'h0000_0000;
    localparam logic                    RST_ENABLE   = 1'b1;
    localparam logic                    WRITE_ENABLE = 1'b1;
    localparam logic                    READ_ENABLE  = 1'b1;
    localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR = 5'b00000;

    // One GPR read port: reset, register 0, write-through bypass, array, idle.
    function automatic logic [REG_BUS-1:0] gpr_read(
        input logic                    rst_v,
        input logic                    re_v,
        input logic [REG_ADDR_BUS-1:0] raddr_v,
        input logic                    wreg_v,
        input logic [REG_ADDR_BUS-1:0] wd_v,
        input logic [REG_BUS-1:0]      wdata_v,
        input logic [REG_BUS-1:0]      array_v
    );
        logic [REG_BUS-1:0] result_v;
        if (rst_v == RST_ENABLE) begin
            result_v = ZERO_WORD;
        end else if (raddr_v == NOP_REG_ADDR) begin
            result_v = ZERO_WORD;
        end else if ((re_v == READ_ENABLE) && (wreg_v == WRITE_ENABLE) && (raddr_v == wd_v)) begin
            result_v = wdata_v;
        end else if (re_v == READ_ENABLE) begin
            result_v = array_v;
        end else begin
            result_v = ZERO_WORD;
        end
        return result_v;
    endfunction

endpackage

// File: rtl/wb_commit_llbit_reg.sv
// llbit_reg: the load-linked bit with its flush/write priority.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush           exception flush, clears the bit and masks a pending write
//   we, value       pending LLbit write from writeback
//   llbit_o         combinational view: pending write wins over stored bit
module llbit_reg
    import wb_commit_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic we,
    input  logic value,
    output logic llbit_o
);

    logic llbit_r;
    logic llbit_s;

    // Stored bit: reset, then flush, then write.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            llbit_r <= 1'b0;
        end else if (flush == 1'b1) begin
            llbit_r <= 1'b0;
        end else if (we == WRITE_ENABLE) begin
            llbit_r <= value;
        end
    end

    // Zero-latency view so an SC in MEM sees an LL that is committing now.
    always_comb begin
        llbit_s = 1'b0;
        if ((rst == RST_ENABLE) || (flush == 1'b1)) begin
            llbit_s = 1'b0;
        end else if (we == WRITE_ENABLE) begin
            llbit_s = value;
        end else begin
            llbit_s = llbit_r;
        end
    end

    assign llbit_o = llbit_s;

endmodule

// File: rtl/wb_commit.sv
// wb_commit: writeback-end state for OpenMIPS (GPR file, HI/LO, LLbit).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush                         exception flush (affects LLbit only)
//   wb_wd/wb_wreg/wb_wdata        GPR write from MEM/WB
//   wb_hi/wb_lo/wb_whilo          HI/LO paired write
//   wb_LLbit_we/wb_LLbit_value    LLbit write
//   re1/raddr1/rdata1, re2/...    ID-stage read ports with write-through bypass
//   hi_o/lo_o                     registered HI/LO (no bypass, EX forwards itself)
//   LLbit_o                       LLbit with same-cycle bypass
module wb_commit
    import wb_commit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [REG_ADDR_BUS-1:0] wb_wd,
    input  logic                    wb_wreg,
    input  logic [REG_BUS-1:0]      wb_wdata,
    input  logic [REG_BUS-1:0]      wb_hi,
    input  logic [REG_BUS-1:0]      wb_lo,
    input  logic                    wb_whilo,
    input  logic                    wb_LLbit_we,
    input  logic                    wb_LLbit_value,
    input  logic                    re1,
    input  logic [REG_ADDR_BUS-1:0] raddr1,
    output logic [REG_BUS-1:0]      rdata1,
    input  logic                    re2,
    input  logic [REG_ADDR_BUS-1:0] raddr2,
    output logic [REG_BUS-1:0]      rdata2,
    output logic [REG_BUS-1:0]      hi_o,
    output logic [REG_BUS-1:0]      lo_o,
    output logic                    LLbit_o
);

    // Entry 0 exists only to keep indexing simple; it is never written and
    // never selected because address 0 is intercepted by gpr_read.
    logic [REG_BUS-1:0] regs_r [0:REG_NUM-1];
    logic [REG_BUS-1:0] hi_r;
    logic [REG_BUS-1:0] lo_r;
    logic [REG_BUS-1:0] rdata1_s;
    logic [REG_BUS-1:0] rdata2_s;

    // GPR array write; contents intentionally not reset.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            // writes dropped while in reset
        end else if ((wb_wreg == WRITE_ENABLE) && (wb_wd != NOP_REG_ADDR)) begin
            regs_r[wb_wd] <= wb_wdata;
        end
    end

    // HI/LO are always written as a pair.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            hi_r <= ZERO_WORD;
            lo_r <= ZERO_WORD;
        end else if (wb_whilo == WRITE_ENABLE) begin
            hi_r <= wb_hi;
            lo_r <= wb_lo;
        end
    end

    // Read ports with write-through bypass of the committing GPR write.
    always_comb begin
        rdata1_s = ZERO_WORD;
        rdata2_s = ZERO_WORD;
        rdata1_s = gpr_read(rst, re1, raddr1, wb_wreg, wb_wd, wb_wdata, regs_r[raddr1]);
        rdata2_s = gpr_read(rst, re2, raddr2, wb_wreg, wb_wd, wb_wdata, regs_r[raddr2]);
    end

    assign rdata1 = rdata1_s;
    assign rdata2 = rdata2_s;
    assign hi_o   = hi_r;
    assign lo_o   = lo_r;

    llbit_reg u_llbit_reg (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .we      (wb_LLbit_we),
        .value   (wb_LLbit_value),
        .llbit_o (LLbit_o)
    );

endmodule

// File: tb/tb_wb_commit.sv
// tb_wb_commit: directed self-checking bench for wb_commit.
module tb_wb_commit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        wb_LLbit_we;
    logic        wb_LLbit_value;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        LLbit_o;

    int n_cmp_s;
    int n_err_s;

    wb_commit dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .wb_wd          (wb_wd),
        .wb_wreg        (wb_wreg),
        .wb_wdata       (wb_wdata),
        .wb_hi          (wb_hi),
        .wb_lo          (wb_lo),
        .wb_whilo       (wb_whilo),
        .wb_LLbit_we    (wb_LLbit_we),
        .wb_LLbit_value (wb_LLbit_value),
        .re1            (re1),
        .raddr1         (raddr1),
        .rdata1         (rdata1),
        .re2            (re2),
        .raddr2         (raddr2),
        .rdata2         (rdata2),
        .hi_o           (hi_o),
        .lo_o           (lo_o),
        .LLbit_o        (LLbit_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp_s++;
        if (got !== exp) begin
            n_err_s++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #2;
    endtask

    initial begin
        n_cmp_s        = 0;
        n_err_s        = 0;
        rst            = 1'b1;
        flush          = 1'b0;
        wb_wd          = 5'd0;
        wb_wreg        = 1'b0;
        wb_wdata       = 32'h0;
        wb_hi          = 32'h0;
        wb_lo          = 32'h0;
        wb_whilo       = 1'b0;
        wb_LLbit_we    = 1'b0;
        wb_LLbit_value = 1'b0;
        re1            = 1'b1;
        raddr1         = 5'd5;
        re2            = 1'b0;
        raddr2         = 5'd0;

        // Reset then read
        settle();
        check_val("rst_rdata1_before_edge", rdata1, 32'h0);
        check_val("rst_llbit_comb", {31'd0, LLbit_o}, 32'h0);
        step();
        check_val("rst_rdata1_cyc1", rdata1, 32'h0);
        check_val("rst_hi_cyc1", hi_o, 32'h0);
        check_val("rst_lo_cyc1", lo_o, 32'h0);
        step();
        rst = 1'b0;
        settle();
        check_val("post_rst_hi", hi_o, 32'h0);
        check_val("post_rst_lo", lo_o, 32'h0);
        check_val("post_rst_llbit", {31'd0, LLbit_o}, 32'h0);

        wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'h1234_5678;
        settle();
        check_val("r5_bypass", rdata1, 32'h1234_5678);
        step();
        wb_wreg = 1'b0; wb_wdata = 32'h0;
        settle();
        check_val("r5_array", rdata1, 32'h1234_5678);

        // Register 0
        wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'hFFFF_FFFF;
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
        settle();
        check_val("r0_p1_same", rdata1, 32'h0);
        check_val("r0_p2_same", rdata2, 32'h0);
        step();
        wb_wreg = 1'b0;
        settle();
        check_val("r0_p1_later", rdata1, 32'h0);
        check_val("r0_p2_later", rdata2, 32'h0);
        step();
        check_val("r0_p1_later2", rdata1, 32'h0);

        // Bypass on both ports, plus an array read during someone else's write
        wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'hDEAD_BEEF;
        raddr1 = 5'd7; raddr2 = 5'd7;
        settle();
        check_val("byp_p1", rdata1, 32'hDEAD_BEEF);
        check_val("byp_p2", rdata2, 32'hDEAD_BEEF);
        re2 = 1'b0;
        settle();
        check_val("byp_p2_disabled", rdata2, 32'h0);
        check_val("byp_p1_still", rdata1, 32'hDEAD_BEEF);
        re2 = 1'b1; raddr2 = 5'd5;
        settle();
        check_val("other_reg_during_write", rdata2, 32'h1234_5678);
        step();
        wb_wreg = 1'b0; wb_wdata = 32'h0; raddr2 = 5'd7;
        settle();
        check_val("r7_array_p2", rdata2, 32'hDEAD_BEEF);
        re1 = 1'b0;
        settle();
        check_val("re1_off_array", rdata1, 32'h0);
        re1 = 1'b1;

        // HI/LO
        wb_whilo = 1'b1; wb_hi = 32'hA; wb_lo = 32'hB;
        settle();
        check_val("hi_no_bypass", hi_o, 32'h0);
        step();
        wb_whilo = 1'b0; wb_hi = 32'hC; wb_lo = 32'hD;
        settle();
        check_val("hi_loaded", hi_o, 32'hA);
        check_val("lo_loaded", lo_o, 32'hB);
        step();
        check_val("hi_held", hi_o, 32'hA);
        check_val("lo_held", lo_o, 32'hB);

        // LLbit
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        settle();
        check_val("ll_bypass", {31'd0, LLbit_o}, 32'h1);
        step();
        wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0;
        settle();
        check_val("ll_stored", {31'd0, LLbit_o}, 32'h1);
        step();
        check_val("ll_stays", {31'd0, LLbit_o}, 32'h1);
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b0;
        settle();
        check_val("ll_bypass_zero", {31'd0, LLbit_o}, 32'h0);
        wb_LLbit_value = 1'b1;
        flush = 1'b1;
        settle();
        check_val("ll_flush_comb", {31'd0, LLbit_o}, 32'h0);
        step();
        flush = 1'b0; wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0;
        settle();
        check_val("ll_flush_stored", {31'd0, LLbit_o}, 32'h0);

        // Reset collision: prime reg 3, HI/LO and LLbit with non-zero state
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        wb_whilo = 1'b1; wb_hi = 32'h55; wb_lo = 32'h66;
        wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'h3333_3333;
        step();
        wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0; wb_whilo = 1'b0; wb_wreg = 1'b0;
        raddr1 = 5'd3;
        settle();
        check_val("prime_r3", rdata1, 32'h3333_3333);
        check_val("prime_hi", hi_o, 32'h55);
        check_val("prime_ll", {31'd0, LLbit_o}, 32'h1);
        rst = 1'b1;
        wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'hBAD0_BAD0;
        wb_whilo = 1'b1; wb_hi = 32'h77; wb_lo = 32'h88;
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        settle();
        check_val("coll_rdata1_in_rst", rdata1, 32'h0);
        check_val("coll_ll_in_rst", {31'd0, LLbit_o}, 32'h0);
        step();
        rst = 1'b0;
        wb_wreg = 1'b0; wb_whilo = 1'b0; wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0;
        settle();
        check_val("coll_r3_kept", rdata1, 32'h3333_3333);
        check_val("coll_hi_zero", hi_o, 32'h0);
        check_val("coll_lo_zero", lo_o, 32'h0);
        check_val("coll_ll_zero", {31'd0, LLbit_o}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp_s, n_err_s);
        $finish;
    end

endmodule

// File: doc/wb_commit.md
# wb_commit

Writeback-end state holder for the OpenMIPS pipeline, consuming the `wb_*` bundle that the MEM/WB pipeline register produces.
- Commits register-file writes, HI/LO writes and LLbit updates on the clock edge.
- Provides the ID-stage read ports with write-through bypass and supplies HI/LO and LLbit state back to the EX/MEM stages.
- Replaces the separate regfile, hilo_reg and LLbit_reg instances with one block sitting after mem_wb.

## Interface
Parameters: none. Widths come from the shared defines: RegBus = 32, RegAddrBus = 5, RegNum = 32.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1'b1).
- `flush`  in  1  exception flush from ctrl; clears LLbit.
- `wb_wd`  in  5  destination GPR address.
- `wb_wreg`  in  1  GPR write enable.
- `wb_wdata`  in  32  GPR write data.
- `wb_hi`, `wb_lo`  in  32 each  HI/LO write data.
- `wb_whilo`  in  1  HI/LO write enable.
- `wb_LLbit_we`  in  1  LLbit write enable.
- `wb_LLbit_value`  in  1  LLbit write value.
- `re1`, `re2`  in  1 each  read enables, ports 1/2.
- `raddr1`, `raddr2`  in  5 each  read addresses.
- `rdata1`, `rdata2`  out  32 each  read data, combinational.
- `hi_o`, `lo_o`  out  32 each  registered HI/LO contents.
- `LLbit_o`  out  1  LLbit with same-cycle bypass, combinational.

## Operation
- **GPR array.** 31 × 32-bit registers for addresses 1–31.
  - Address 0 always reads `ZeroWord`; writes to address 0 are discarded.
  - Array contents are not reset.
- **GPR write.** On the clock edge, if `rst`=0, `wb_wreg`=1 and `wb_wd`≠0, then `regs[wb_wd]` ← `wb_wdata`.
- **GPR read, per port n.** First matching rule wins:
  1. `rst`=1 → `ZeroWord`.
  2. `raddrn`=0 → `ZeroWord`.
  3. `ren`=1, `wb_wreg`=1 and `raddrn`=`wb_wd` → `wb_wdata` (bypass).
  4. `ren`=1 → `regs[raddrn]`.
  5. Otherwise → `ZeroWord`.
- **HI/LO.**
  - `rst` → both 0.
  - Otherwise, if `wb_whilo`=1, both are loaded together from `wb_hi`/`wb_lo`.
  - There are no partial writes.
- **LLbit register.**
  - `rst` → 0.
  - Otherwise `flush`=1 → 0.
  - Otherwise, if `wb_LLbit_we`=1 → `wb_LLbit_value`.
- **LLbit_o.**
  - `rst` or `flush` → 0.
  - Otherwise, if `wb_LLbit_we`=1 → `wb_LLbit_value`.
  - Otherwise the stored bit.
- **Simultaneous events.**
  - `rst` beats every write.
  - `flush` beats `wb_LLbit_we`.
  - `flush` has no effect on GPR or HI/LO writes, because mem_wb has already nulled flushed instructions.
  - Both ports may read the same address concurrently, and may read the address being written; both receive bypassed data.

## Timing
- **Reset values.**
  - `rdata1` and `rdata2` are 0 while `rst`=1.
  - `hi_o`, `lo_o` and `LLbit_o` are 0 in the cycle after reset is sampled; `LLbit_o` is also 0 combinationally while `rst`=1.
- **GPR write latency.** A write presented in cycle N is visible on the read ports in cycle N through the bypass, and from the array from cycle N+1.
- **HI/LO latency.** `hi_o`/`lo_o` update one cycle after `wb_whilo`. They are not bypassed, because EX performs its own MEM/WB HI/LO forwarding.
- **LLbit latency.** Zero-latency view of a pending write; the stored value updates at the edge.
- **Stalls.** No stall input. mem_wb inserts bubbles (`wb_wreg`=0, `wb_whilo`=0, `wb_LLbit_we`=0), so holding state needs no extra logic.
- **Reset during operation.** Reset takes effect at the next edge. In-flight writes in that cycle are dropped; GPR contents are retained but unobservable while `rst`=1.

## Structure
- Widths and constants come from the shared `define.v`:
  - widths: `RegBus`, `RegAddrBus`, `RegNum`, `RegNumLog2`;
  - constants: `ZeroWord`, `RstEnable`, `WriteEnable`, `ReadEnable`, `NOPRegAddr`.
- No new constants are needed.
- Natural sub-module: `llbit_reg`, holding the LLbit register plus its flush/bypass priority logic.
- The GPR array and HI/LO stay inline in `wb_commit`.

## Test plan
- **Reset then read.** Hold `rst` 2 cycles, `re1`=1, `raddr1`=5 → `rdata1`=0 and `hi_o`=`lo_o`=0 during and after reset; then write reg 5 = 0x1234_5678 → read back 0x1234_5678.
- **Register 0.** `wb_wd`=0, `wb_wreg`=1, `wb_wdata`=0xFFFF_FFFF → reading address 0 on both ports returns 0, in the same cycle and all later cycles.
- **Bypass.** Write reg 7 = 0xDEAD_BEEF while both ports read address 7 in the same cycle → both return 0xDEAD_BEEF combinationally. With `re2`=0 in that cycle → `rdata2`=0.
- **HI/LO.** `wb_whilo`=1, `wb_hi`=0xA, `wb_lo`=0xB → `hi_o`=0xA, `lo_o`=0xB from the next cycle; `wb_whilo`=0 with new data → values unchanged.
- **LLbit.**
  - `wb_LLbit_we`=1, value=1 → `LLbit_o`=1 in the same cycle and stays 1.
  - Then `flush`=1 together with `wb_LLbit_we`=1, value=1 → `LLbit_o`=0 in that cycle and the stored bit is 0 afterwards.
- **Reset collision.** `rst`=1 with `wb_wreg`=1 to reg 3, `wb_whilo`=1 and `wb_LLbit_we`=1 → after reset, reg 3 holds its previous value, HI/LO=0 and LLbit=0.
